// File: rtl/alu_bitserial_seq_if.sv
// Request/response bundle between the bit-serial ALU sequencer and its pipeline stage.
// master = requester/consumer side, slave = sequencer side.
interface alu_bitserial_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7_b5;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, alu_op, funct3, funct7_b5, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct3, funct7_b5, op_a, op_b, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero, illegal
    );
endinterface

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: decodes ALUOp/funct3/funct7[5] and walks operands LSB-first through a 1-bit ALU slice.
// Optional macro ALU_SEQ_OPCOUNT_EN adds a saturating completed-operation counter (op_count).
module alu_bitserial_seq #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_bitserial_seq_if.slave  bus,
    output logic                slice_a,
    output logic                slice_b,
    output logic                slice_cin,
    output logic [3:0]          slice_op,
    input  logic                slice_out,
    input  logic                slice_cout
`ifdef ALU_SEQ_OPCOUNT_EN
    ,
    output logic [15:0]         op_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_final;
    logic [3:0]       op_reg, dec_op;
    logic [IDX_W-1:0] idx;
    logic             carry_reg, cin_msb, zero_reg, illegal_reg;
    logic             dec_ok, arith, sub_like, last, accept, ovf_now;

    // Request decode, only consumed on the acceptance clock.
    always_comb begin
        dec_op = 4'b0000;
        dec_ok = 1'b1;
        case (bus.alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  dec_op = bus.funct7_b5 ? OP_SUB : OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    3'b010:  dec_op = OP_SLT;
                    default: dec_ok = 1'b0;
                endcase
            end
            default: begin
                case (bus.funct3)
                    3'b000:  dec_op = OP_NAND;
                    3'b001:  dec_op = OP_NOR;
                    default: dec_ok = 1'b0;
                endcase
            end
        endcase
    end

    // ADD/SUB/SLT are the only codes with bit1 set and bit3 clear; SUB/SLT add bit2.
    assign arith    = op_reg[1] & ~op_reg[3];
    assign sub_like = arith & op_reg[2];
    assign last     = (idx == LAST_IDX);
    assign accept   = (state == IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_op  = 4'b0000;
        case (state)
            IDLE: begin
                if (bus.in_valid) state_nx = dec_ok ? RUN : DONE;
            end
            RUN: begin
                slice_a   = a_reg[idx];
                slice_b   = b_reg[idx];
                slice_op  = op_reg;
                slice_cin = arith ? ((idx == '0) ? sub_like : carry_reg) : 1'b0;
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Signed overflow at the MSB: carry into vs. carry out of the top bit.
    assign ovf_now = arith & (slice_cout ^ slice_cin);

    always_comb begin
        res_final      = res_reg;
        res_final[idx] = slice_out;
        if (last && (op_reg == OP_SLT))
            res_final = {{(WIDTH-1){1'b0}}, slice_out ^ ovf_now};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= 4'b0000;
            idx         <= '0;
            res_reg     <= '0;
            carry_reg   <= 1'b0;
            cin_msb     <= 1'b0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (accept) begin
            a_reg       <= bus.op_a;
            b_reg       <= bus.op_b;
            op_reg      <= dec_ok ? dec_op : 4'b0000;
            idx         <= '0;
            res_reg     <= '0;
            carry_reg   <= 1'b0;
            cin_msb     <= 1'b0;
            zero_reg    <= ~dec_ok;
            illegal_reg <= ~dec_ok;
        end else if (state == RUN) begin
            res_reg   <= res_final;
            carry_reg <= slice_cout;
            idx       <= idx + 1'b1;
            if (last) begin
                cin_msb  <= slice_cin;
                zero_reg <= (res_final == '0);
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_reg;
    assign bus.carry_out = carry_reg;
    assign bus.overflow  = arith & (carry_reg ^ cin_msb);
    assign bus.zero      = zero_reg;
    assign bus.illegal   = illegal_reg;

`ifdef ALU_SEQ_OPCOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= 16'h0000;
        else if ((state == DONE) && bus.out_ready && (op_count != 16'hFFFF))
            op_count <= op_count + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Bench for alu_bitserial_seq: behavioural 1-bit slice, arithmetic reference model and a result scoreboard.
module tb_alu_bitserial_seq;
    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] res;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        ill;
        logic        chk_carry;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic slice_a, slice_b, slice_cin, slice_out, slice_cout;
    logic [3:0] slice_op;
    logic sa, sb;
`ifdef ALU_SEQ_OPCOUNT_EN
    logic [15:0] op_count;
`endif

    int errors = 0;
    int checks = 0;
    int op_id = 0;
    int opcnt_exp = 0;
    exp_t exp_q[$];

    alu_bitserial_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_bitserial_seq #(.WIDTH(WIDTH), .IDX_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_op   (slice_op),
        .slice_out  (slice_out),
        .slice_cout (slice_cout)
`ifdef ALU_SEQ_OPCOUNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    always #5 clk = ~clk;

    // 1-bit slice: Ainvert=op[3], Binvert=op[2], op[1:0] selects AND/OR/sum.
    always_comb begin
        sa = slice_a ^ slice_op[3];
        sb = slice_b ^ slice_op[2];
        slice_cout = (sa & sb) | (sa & slice_cin) | (sb & slice_cin);
        case (slice_op[1:0])
            2'b00:   slice_out = sa & sb;
            2'b01:   slice_out = sa | sb;
            default: slice_out = sa ^ sb ^ slice_cin;
        endcase
    end

    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] s;
        int kind;
        kind = 7;
        if (op == 2'b00) kind = 0;
        else if (op == 2'b01) kind = 1;
        else if (op == 2'b10) begin
            if (f3 == 3'b000) kind = f7 ? 1 : 0;
            else if (f3 == 3'b111) kind = 3;
            else if (f3 == 3'b110) kind = 4;
            else if (f3 == 3'b010) kind = 2;
        end else begin
            if (f3 == 3'b000) kind = 5;
            else if (f3 == 3'b001) kind = 6;
        end
        e.res = '0; e.carry = 1'b0; e.ovf = 1'b0; e.ill = 1'b0; e.chk_carry = 1'b1;
        case (kind)
            0: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[31:0]; e.carry = s[32];
                e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
            end
            1, 2: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.carry = s[32];
                e.ovf = (a[31] != b[31]) && (s[31] != a[31]);
                e.res = (kind == 1) ? s[31:0] : (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            end
            3: begin e.res = a & b;    e.chk_carry = 1'b0; end
            4: begin e.res = a | b;    e.chk_carry = 1'b0; end
            5: begin e.res = ~(a & b); e.chk_carry = 1'b0; end
            6: begin e.res = ~(a | b); e.chk_carry = 1'b0; end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Scoreboard: compare at the sample point preceding each output handshake.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL unexpected_output result=%h", bus.result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                opcnt_exp++;
                checks++;
                if (bus.result !== e.res) begin
                    errors++; $display("FAIL op%0d result got=%h want=%h", e.id, bus.result, e.res);
                end
                checks++;
                if (bus.overflow !== e.ovf) begin
                    errors++; $display("FAIL op%0d overflow got=%b want=%b", e.id, bus.overflow, e.ovf);
                end
                checks++;
                if (bus.zero !== e.zero) begin
                    errors++; $display("FAIL op%0d zero got=%b want=%b", e.id, bus.zero, e.zero);
                end
                checks++;
                if (bus.illegal !== e.ill) begin
                    errors++; $display("FAIL op%0d illegal got=%b want=%b", e.id, bus.illegal, e.ill);
                end
                if (e.chk_carry) begin
                    checks++;
                    if (bus.carry_out !== e.carry) begin
                        errors++; $display("FAIL op%0d carry_out got=%b want=%b", e.id, bus.carry_out, e.carry);
                    end
                end
            end
        end
    end

    // Drives one request, observes the run phase, optionally stalls the consumer, then completes the handshake.
    task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input int hold,
                          output int runs, output int cin_hi, output bit stable, output bit idle_ok);
        exp_t e;
        bit seen;
        logic [31:0] snap_res;
        logic [3:0] snap_flags;
        e = model(op, f3, f7, a, b);
        e.id = op_id++;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.alu_op = op; bus.funct3 = f3; bus.funct7_b5 = f7;
        bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        runs = 0; cin_hi = 0; seen = 1'b0; stable = 1'b1; idle_ok = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else begin
                if (!bus.in_ready) runs++;
                if (slice_cin) cin_hi++;
            end
        end
        if (!seen) begin
            runs = -1;
            void'(exp_q.pop_back());
            return;
        end
        snap_res = bus.result;
        snap_flags = {bus.carry_out, bus.overflow, bus.zero, bus.illegal};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.result !== snap_res ||
                {bus.carry_out, bus.overflow, bus.zero, bus.illegal} !== snap_flags)
                stable = 1'b0;
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(negedge clk);
        idle_ok = !bus.out_valid && bus.in_ready;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.illegal, bus.zero} !== 4'b1000 || bus.result !== 32'd0) begin
            errors++; $display("FAIL reset_outputs got rdy/vld/ill/zero=%b result=%h want 1000/0",
                               {bus.in_ready, bus.out_valid, bus.illegal, bus.zero}, bus.result);
        end
        checks++;
        if ({slice_a, slice_b, slice_cin, slice_op} !== 7'd0) begin
            errors++; $display("FAIL reset_slice got=%b want=0", {slice_a, slice_b, slice_cin, slice_op});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL reset_release rdy=%b vld=%b c=%b v=%b want 1 0 0 0",
                               bus.in_ready, bus.out_valid, bus.carry_out, bus.overflow);
        end
`ifdef ALU_SEQ_OPCOUNT_EN
        checks++;
        if (op_count !== 16'd0) begin
            errors++; $display("FAIL reset_op_count got=%0d want=0", op_count);
        end
`endif
    endtask

    task automatic test_add();
        int runs, cin_hi; bit st, idl;
        run_op(2'b00, 3'b000, 1'b0, 32'd5, 32'd3, 0, runs, cin_hi, st, idl);
        checks++;
        if (runs != WIDTH) begin
            errors++; $display("FAIL add_latency run_cycles got=%0d want=%0d", runs, WIDTH);
        end
        checks++;
        if (!idl) begin
            errors++; $display("FAIL add_return_idle got=0 want=1");
        end
    endtask

    task automatic test_sub();
        int runs, cin_hi; bit st, idl;
        run_op(2'b10, 3'b000, 1'b1, 32'd3, 32'd5, 0, runs, cin_hi, st, idl);
        checks++;
        if (runs != WIDTH) begin
            errors++; $display("FAIL sub_latency run_cycles got=%0d want=%0d", runs, WIDTH);
        end
        run_op(2'b10, 3'b000, 1'b1, 32'd7, 32'd7, 0, runs, cin_hi, st, idl);
        run_op(2'b01, 3'b101, 1'b0, 32'd100, 32'd1, 0, runs, cin_hi, st, idl);
    endtask

    task automatic test_overflow_slt();
        int runs, cin_hi; bit st, idl;
        run_op(2'b00, 3'b000, 1'b0, 32'h7FFFFFFF, 32'd1, 0, runs, cin_hi, st, idl);
        run_op(2'b10, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 0, runs, cin_hi, st, idl);
        run_op(2'b10, 3'b010, 1'b0, 32'h80000000, 32'd1, 0, runs, cin_hi, st, idl);
        run_op(2'b10, 3'b010, 1'b0, 32'd5, 32'd3, 0, runs, cin_hi, st, idl);
        checks++;
        if (runs != WIDTH) begin
            errors++; $display("FAIL slt_latency run_cycles got=%0d want=%0d", runs, WIDTH);
        end
    endtask

    task automatic test_logic();
        logic [1:0] ops[4] = '{2'b10, 2'b10, 2'b11, 2'b11};
        logic [2:0] f3s[4] = '{3'b111, 3'b110, 3'b000, 3'b001};
        int runs, cin_hi; bit st, idl;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], f3s[i], 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 0, runs, cin_hi, st, idl);
            checks++;
            if (cin_hi != 0 || runs != WIDTH) begin
                errors++; $display("FAIL logic%0d cin_high_cycles=%0d runs=%0d want 0/%0d", i, cin_hi, runs, WIDTH);
            end
        end
    endtask

    task automatic test_illegal_hold();
        int runs, cin_hi; bit st, idl;
        run_op(2'b10, 3'b001, 1'b0, 32'h12345678, 32'h9, 5, runs, cin_hi, st, idl);
        checks++;
        if (runs != 0) begin
            errors++; $display("FAIL illegal_run_cycles got=%0d want=0", runs);
        end
        checks++;
        if (!st) begin
            errors++; $display("FAIL illegal_hold_stable got=0 want=1");
        end
        checks++;
        if (!idl) begin
            errors++; $display("FAIL illegal_return_idle got=0 want=1");
        end
        run_op(2'b11, 3'b010, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, runs, cin_hi, st, idl);
        checks++;
        if (runs != 0 || !st) begin
            errors++; $display("FAIL illegal2 runs=%0d stable=%b want 0/1", runs, st);
        end
    endtask

    task automatic test_reset_mid_op();
        int n, runs, cin_hi; bit st, idl;
        @(posedge clk); #1;
        bus.alu_op = 2'b00; bus.funct3 = 3'b000; bus.funct7_b5 = 1'b0;
        bus.op_a = 32'd11; bus.op_b = 32'd22; bus.in_valid = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 11; c++) begin
            @(negedge clk);
            if (!bus.in_ready && !bus.out_valid) n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (n != 11 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || slice_op !== 4'b0000) begin
            errors++; $display("FAIL midop_reset n=%0d rdy=%b vld=%b slice_op=%b want 11/1/0/0000",
                               n, bus.in_ready, bus.out_valid, slice_op);
        end
        @(negedge clk);
        rst_n = 1'b1;
        opcnt_exp = 0;
        run_op(2'b00, 3'b000, 1'b0, 32'd40, 32'd2, 0, runs, cin_hi, st, idl);
        checks++;
        if (runs != WIDTH || !idl) begin
            errors++; $display("FAIL post_reset_op runs=%0d idle=%b want %0d/1", runs, idl, WIDTH);
        end
`ifdef ALU_SEQ_OPCOUNT_EN
        checks++;
        if (op_count !== 16'(opcnt_exp)) begin
            errors++; $display("FAIL op_count got=%0d want=%0d", op_count, opcnt_exp);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int runs, cin_hi; bit st, idl;
        logic [1:0] op;
        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 2));
            run_op(op, 3'b000, 1'($urandom_range(0, 1)), $urandom, $urandom, 0, runs, cin_hi, st, idl);
            checks++;
            if (runs != WIDTH) begin
                errors++; $display("FAIL b2b%0d run_cycles got=%0d want=%0d", i, runs, WIDTH);
            end
        end
`ifdef ALU_SEQ_OPCOUNT_EN
        checks++;
        if (op_count !== 16'(opcnt_exp)) begin
            errors++; $display("FAIL op_count_b2b got=%0d want=%0d", op_count, opcnt_exp);
        end
`endif
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.alu_op = 2'b00; bus.funct3 = 3'b000; bus.funct7_b5 = 1'b0;
        bus.op_a = '0; bus.op_b = '0;
        test_reset();
        test_add();
        test_sub();
        test_overflow_slt();
        test_logic();
        test_illegal_hold();
        test_reset_mid_op();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_bitserial_seq.md
Name: alu_bitserial_seq

Overview:
- Sequencer that sits upstream of the existing 1-bit ALU slice and drives its operand, carry-in and 4-bit Operation inputs.
- Decodes RISC-V ALUOp/funct3/funct7[5] into the slice Operation code.
- Walks a WIDTH-bit operand pair through the slice LSB-first, one bit per clock, chaining carry.
- Returns the assembled result and flags over a valid/ready handshake. Intended as the area-minimal execute unit of the pipelined CPU.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- IDX_W, 5, width of the bit-index counter; must satisfy 2^IDX_W >= WIDTH.

Ports:
- clk, input, 1, rising-edge clock
- rst_n, input, 1, asynchronous active-low reset
- in_valid, input, 1, request valid
- in_ready, output, 1, block can accept a request
- alu_op, input, 2, 00 add, 01 sub, 10 R/I decode, 11 inverted logic
- funct3, input, 3, instruction funct3
- funct7_b5, input, 1, instruction bit 30
- op_a, input, WIDTH, operand A
- op_b, input, WIDTH, operand B
- slice_a, output, 1, to slice A
- slice_b, output, 1, to slice B
- slice_cin, output, 1, to slice alu_carry_in
- slice_op, output, 4, to slice Operation
- slice_out, input, 1, from slice alu_out
- slice_cout, input, 1, from slice alu_carry_out
- out_valid, output, 1, result valid
- out_ready, input, 1, consumer accepts result
- result, output, WIDTH, assembled result
- carry_out, output, 1, final MSB carry
- overflow, output, 1, signed overflow (add/sub/slt only, else 0)
- zero, output, 1, result == 0
- illegal, output, 1, undecodable request

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=1; out_valid, result, carry_out, overflow, zero, illegal=0. slice_a, slice_b, slice_cin=0; slice_op=4'b0000. A reset mid-RUN aborts the operation with no output.
- Decode, latched at acceptance:
  - alu_op 00 -> 0010 ADD.
  - alu_op 01 -> 0110 SUB.
  - alu_op 10: funct3 000 -> funct7_b5 ? 0110 SUB : 0010 ADD; 111 -> 0000 AND; 110 -> 0001 OR; 010 -> 0111 SLT; any other funct3 is illegal.
  - alu_op 11: funct3 000 -> 1101 NAND; 001 -> 1100 NOR; any other funct3 is illegal.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid=1, latch operands and op, clear idx/result. Go to RUN, or to DONE directly with illegal=1 and result=0 if undecodable.
  - RUN: in_ready=0. Combinationally slice_a=a_reg[idx], slice_b=b_reg[idx], slice_op=op_reg. slice_cin = idx==0 ? (op is SUB/SLT) : carry_reg; logic ops always drive cin 0. Each clock: res_reg[idx]<=slice_out, carry_reg<=slice_cout, idx<=idx+1. At idx==WIDTH-1, also capture cin_msb=slice_cin and sum_msb=slice_out, then go to DONE.
  - DONE: out_valid=1. Outputs stay stable until out_ready=1; on that clock return to IDLE with out_valid<=0.
- Latency: exactly WIDTH RUN cycles. out_valid rises on cycle WIDTH+1 after acceptance. Throughput is one op per WIDTH+2 cycles minimum.
- Flags:
  - carry_out = final carry_reg.
  - overflow = carry_reg XOR cin_msb for ADD/SUB/SLT, else 0.
  - SLT: result = {0..0, sum_msb XOR overflow}; carry_out and overflow still reported.
  - zero computed on the final result.
  - Illegal requests: carry_out=overflow=0, zero=1.
- Outside RUN, slice inputs are driven to 0 and slice_op to 0000.
- in_valid during RUN/DONE is ignored; the requester must hold it, since in_ready=0.
- out_ready while not DONE has no effect.

Optional Feature:
- Macro ALU_SEQ_OPCOUNT_EN.
- Defined: adds output op_count[15:0], reset to 0. It increments on each DONE->IDLE handshake, including illegal requests, and saturates at 16'hFFFF.
- Undefined: no port and no counter logic; all other behaviour identical.

Test Plan:
- ADD, WIDTH=32: alu_op=00, A=5, B=3 -> after 32 RUN cycles out_valid=1, result=8, carry_out=0, overflow=0, zero=0.
- SUB via R-type: alu_op=10, funct3=000, funct7_b5=1, A=3, B=5 -> result=0xFFFFFFFE, carry_out=0, overflow=0. Same op with A=B=7 -> result=0, zero=1, carry_out=1.
- Overflow and SLT:
  - ADD A=0x7FFFFFFF, B=1 -> result=0x80000000, overflow=1.
  - SLT A=0xFFFFFFFF, B=1 -> result=1.
  - SLT A=0x80000000, B=1 -> result=1 (overflow corrected).
- Logic ops with A=0xF0F0F0F0, B=0xFF00FF00:
  - AND -> 0xF000F000.
  - OR -> 0xFFF0FFF0.
  - NAND -> 0x0FFF0FFF.
  - NOR -> 0x000F000F.
  - Check slice_cin=0 on every cycle.
- Illegal: alu_op=10, funct3=001 -> next cycle DONE, illegal=1, result=0, zero=1, no RUN cycles. Hold out_ready=0 for 5 cycles -> outputs stable; out_ready=1 -> IDLE, in_ready=1.
- Reset mid-op: drop rst_n at RUN idx=10 -> immediately in_ready=1, out_valid=0, slice_op=0000. The next request completes normally. With ALU_SEQ_OPCOUNT_EN defined, op_count excludes the aborted operation.
